// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor: observes the LED position/colour buses and recovers the
// shift rate, the active colour and whether the pattern is still advancing.
// It also raises sticky error flags for illegal patterns.
// Optional build macro LED_SEQ_CHECK_EN adds o_err[3]. When it is set, every
// step must be a rotate-left-by-one of the previous pattern.
module led_pattern_monitor #(
  parameter int NB_LEDS    = 4,
  parameter int NB_COUNTER = 16,
  parameter int LIM_R0     = 64,
  parameter int LIM_R1     = 128,
  parameter int LIM_R2     = 256,
  parameter int LIM_R3     = 512,
  parameter int TOL        = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_LEDS-1:0] i_led,
  input  logic [NB_LEDS-1:0] i_led_b,
  input  logic [NB_LEDS-1:0] i_led_g,
  input  logic               i_clr,
  output logic [1:0]         o_speed,
  output logic               o_color,
  output logic               o_valid,
  output logic               o_running,
`ifdef LED_SEQ_CHECK_EN
  output logic [3:0]         o_err
`else
  output logic [2:0]         o_err
`endif
);

`ifdef LED_SEQ_CHECK_EN
  localparam int NB_ERR = 4;
`else
  localparam int NB_ERR = 3;
`endif

  // Interval arithmetic uses one extra bit so LIM-TOL and counter+1 never wrap.
  localparam int W = NB_COUNTER + 1;
  localparam logic [NB_COUNTER:0] LO_R0     = W'(LIM_R0 - TOL);
  localparam logic [NB_COUNTER:0] HI_R0     = W'(LIM_R0 + TOL);
  localparam logic [NB_COUNTER:0] LO_R1     = W'(LIM_R1 - TOL);
  localparam logic [NB_COUNTER:0] HI_R1     = W'(LIM_R1 + TOL);
  localparam logic [NB_COUNTER:0] LO_R2     = W'(LIM_R2 - TOL);
  localparam logic [NB_COUNTER:0] HI_R2     = W'(LIM_R2 + TOL);
  localparam logic [NB_COUNTER:0] LO_R3     = W'(LIM_R3 - TOL);
  localparam logic [NB_COUNTER:0] HI_R3     = W'(LIM_R3 + TOL);
  localparam logic [NB_COUNTER:0] STALL_LIM = W'(LIM_R3 + TOL);
  localparam logic [NB_COUNTER-1:0] CNT_MAX = {NB_COUNTER{1'b1}};
  localparam logic [NB_LEDS-1:0]    LEDS_ZERO = {NB_LEDS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_STALL  = 2'd3
  } state_t;

  // True when v has exactly one bit set.
  function automatic logic is_onehot(input logic [NB_LEDS-1:0] v);
    return (v != LEDS_ZERO) && ((v & (v - NB_LEDS'(1))) == LEDS_ZERO);
  endfunction

  // True when iv lies inside the inclusive window [lo, hi].
  function automatic logic in_window(input logic [NB_COUNTER:0] iv,
                                     input logic [NB_COUNTER:0] lo,
                                     input logic [NB_COUNTER:0] hi);
    return (iv >= lo) && (iv <= hi);
  endfunction

`ifdef LED_SEQ_CHECK_EN
  // Rotate left by one position, MSB wraps into bit 0.
  function automatic logic [NB_LEDS-1:0] rotl1(input logic [NB_LEDS-1:0] v);
    return {v[NB_LEDS-2:0], v[NB_LEDS-1]};
  endfunction
`endif

  logic [NB_LEDS-1:0]    led_q, led_dly_q, led_b_q, led_g_q;
  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [1:0]            speed_q, speed_d;
  logic                  color_q, color_d;
  logic                  valid_q, valid_d;
  logic                  running_q, running_d;
  logic [NB_ERR-1:0]     err_q, err_d, err_new_s;
  logic                  change_s;
  logic [NB_COUNTER:0]   interval_s;
  logic                  match_s;
  logic [1:0]            rate_s;

  assign change_s   = (led_q != led_dly_q);
  // The counter is cleared on the event edge, so it reads one less than the interval.
  assign interval_s = {1'b0, cnt_q} + W'(1);

  // Input sampling stage and the one-cycle delayed position pattern.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      led_q     <= LEDS_ZERO;
      led_dly_q <= LEDS_ZERO;
      led_b_q   <= LEDS_ZERO;
      led_g_q   <= LEDS_ZERO;
    end else begin
      led_q     <= i_led;
      led_dly_q <= led_q;
      led_b_q   <= i_led_b;
      led_g_q   <= i_led_g;
    end
  end

  // Interval classification: the lowest matching rate index wins.
  always_comb begin
    match_s = 1'b0;
    rate_s  = 2'd0;
    if (in_window(interval_s, LO_R0, HI_R0)) begin
      match_s = 1'b1;
      rate_s  = 2'd0;
    end else if (in_window(interval_s, LO_R1, HI_R1)) begin
      match_s = 1'b1;
      rate_s  = 2'd1;
    end else if (in_window(interval_s, LO_R2, HI_R2)) begin
      match_s = 1'b1;
      rate_s  = 2'd2;
    end else if (in_window(interval_s, LO_R3, HI_R3)) begin
      match_s = 1'b1;
      rate_s  = 2'd3;
    end else begin
      match_s = 1'b0;
      rate_s  = 2'd0;
    end
  end

  // Next-state logic for the FSM, the counter, the recovered settings and the errors.
  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    color_d   = color_q;
    valid_d   = valid_q;
    err_new_s = {NB_ERR{1'b0}};

    if (change_s) begin
      cnt_d = {NB_COUNTER{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + NB_COUNTER'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (change_s) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC, ST_LOCKED: begin
        if (change_s) begin
          if (match_s) begin
            speed_d = rate_s;
            valid_d = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            err_new_s[2] = 1'b1;
            valid_d      = 1'b0;
            state_d      = ST_SYNC;
          end
        end else if ({1'b0, cnt_q} > STALL_LIM) begin
          state_d = ST_STALL;
        end else begin
          state_d = state_q;
        end
      end
      ST_STALL: begin
        if (change_s) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Colour is tracked every cycle. An ambiguous colour holds the last value.
    if ((led_b_q != LEDS_ZERO) && (led_g_q == LEDS_ZERO)) begin
      color_d = 1'b0;
    end else if ((led_g_q != LEDS_ZERO) && (led_b_q == LEDS_ZERO)) begin
      color_d = 1'b1;
    end else if ((led_b_q != LEDS_ZERO) || (led_q != LEDS_ZERO)) begin
      err_new_s[1] = 1'b1;
    end else begin
      color_d = color_q;
    end

    if ((state_q != ST_IDLE) && !is_onehot(led_q)) begin
      err_new_s[0] = 1'b1;
    end else begin
      err_new_s[0] = err_new_s[0];
    end

`ifdef LED_SEQ_CHECK_EN
    if (change_s && ((state_q == ST_SYNC) || (state_q == ST_LOCKED)) &&
        (led_q != rotl1(led_dly_q))) begin
      err_new_s[3] = 1'b1;
    end else begin
      err_new_s[3] = err_new_s[3];
    end
`endif

    // A clear and a fresh error in the same cycle leave the fresh error set.
    if (i_clr) begin
      err_d = err_new_s;
    end else begin
      err_d = err_q | err_new_s;
    end

    running_d = (state_d == ST_LOCKED);
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {NB_COUNTER{1'b0}};
      speed_q   <= 2'd0;
      color_q   <= 1'b0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      err_q     <= {NB_ERR{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      speed_q   <= speed_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      err_q     <= err_d;
    end
  end

  assign o_speed   = speed_q;
  assign o_color   = color_q;
  assign o_valid   = valid_q;
  assign o_running = running_q;
  assign o_err     = err_q;

endmodule
